// File: rtl/mc_adr_gen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_pkg : shared encodings and geometry helpers for the address generator
// Rev 1.0
// ----------------------------------------------------------------------------
package mc_pkg;

  localparam logic [1:0] MC_BW_8  = 2'd0;
  localparam logic [1:0] MC_BW_16 = 2'd1;
  localparam logic [1:0] MC_BW_32 = 2'd2;

  localparam logic [1:0] MC_MEM_SIZE_64  = 2'd0;
  localparam logic [1:0] MC_MEM_SIZE_128 = 2'd1;
  localparam logic [1:0] MC_MEM_SIZE_256 = 2'd2;

  typedef enum logic [2:0] {
    MC_MEM_TYPE_SDRAM = 3'd0,
    MC_MEM_TYPE_SRAM  = 3'd1,
    MC_MEM_TYPE_ACS   = 3'd2,
    MC_MEM_TYPE_SCS   = 3'd3
  } mem_type_e;

  typedef enum logic [2:0] {
    MC_BL_1    = 3'd0,
    MC_BL_2    = 3'd1,
    MC_BL_4    = 3'd2,
    MC_BL_8    = 3'd3,
    MC_BL_PAGE = 3'd7
  } bl_code_e;

  function automatic logic [4:0] col_bits(input logic [1:0] bw, input logic [1:0] ms);
    logic [4:0] n;
    n = 5'd8;
    case (bw)
      MC_BW_8:  n = (ms == MC_MEM_SIZE_64) ? 5'd9 : 5'd10;
      MC_BW_16: n = (ms == MC_MEM_SIZE_64) ? 5'd8 : 5'd9;
      default:  n = 5'd8;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] row_bits(input logic [1:0] bw, input logic [1:0] ms);
    logic [4:0] n;
    n = 5'd11;
    if (bw == MC_BW_8 || bw == MC_BW_16) begin
      n = (ms == MC_MEM_SIZE_64 || ms == MC_MEM_SIZE_128) ? 5'd12 : 5'd13;
    end
    return n;
  endfunction

  function automatic logic [4:0] byte_shift(input logic [1:0] bw);
    logic [4:0] n;
    case (bw)
      MC_BW_8:  n = 5'd0;
      MC_BW_16: n = 5'd1;
      default:  n = 5'd2;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] low_mask(input logic [4:0] n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_adr_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_adr_gen_if : command/address bundle between controller FSM and mc_adr_gen
// Rev 1.0
// ----------------------------------------------------------------------------
interface mc_adr_gen_if #(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int BANK_W = 2,
  parameter int ADR_W  = 24
);
  logic [31:0]       csc;
  logic [31:0]       tms;
  logic [31:0]       wb_addr_i;
  logic              cs_le;
  logic              act;
  logic              pre;
  logic              rfr_ack;
  logic              lmr_sel;
  logic              cas_;
  logic              row_sel;
  logic              cmd_a10;
  logic              col_go;
  logic              next_adr;
  logic [ADR_W-1:0]  mc_addr;
  logic [BANK_W-1:0] bank_adr;
  logic [ROW_W-1:0]  row_adr;
  logic [COL_W-1:0]  col_adr;
  logic [10:0]       page_size;
  logic              page_hit;
  logic              bank_open;
  logic              burst_last;

  modport master (
    output csc, tms, wb_addr_i, cs_le, act, pre, rfr_ack, lmr_sel, cas_,
           row_sel, cmd_a10, col_go, next_adr,
    input  mc_addr, bank_adr, row_adr, col_adr, page_size, page_hit,
           bank_open, burst_last
  );

  modport slave (
    input  csc, tms, wb_addr_i, cs_le, act, pre, rfr_ack, lmr_sel, cas_,
           row_sel, cmd_a10, col_go, next_adr,
    output mc_addr, bank_adr, row_adr, col_adr, page_size, page_hit,
           bank_open, burst_last
  );
endinterface
`default_nettype wire

// File: rtl/mc_adr_gen_open_row_tbl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_open_row_tbl : per-bank open-row table with activate/precharge update
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_open_row_tbl #(
  parameter int ROW_W  = 13,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic              pre,
  input  logic              pre_all,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  output logic              page_hit,
  output logic              bank_open
);
  localparam int NBANK = 1 << BANK_W;

  logic [NBANK-1:0] r_valid;
  logic [ROW_W-1:0] r_row [NBANK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NBANK; i++) r_row[i] <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        // precharge dominates a coincident activate on the same entry
        if (pre && (pre_all || bank == BANK_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (act && bank == BANK_W'(i)) begin
          r_valid[i] <= 1'b1;
          r_row[i]   <= row;
        end
      end
    end
  end

  assign bank_open = r_valid[bank];
  assign page_hit  = r_valid[bank] && (r_row[bank] == row);

endmodule
`default_nettype wire

// File: rtl/mc_adr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_adr_gen : geometry-aware bank/row/column decode, burst counter, mc_addr mux
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_adr_gen
  import mc_pkg::*;
#(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int BANK_W = 2,
  parameter int ADR_W  = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_adr_gen_if.slave  bus
);
  localparam logic [4:0] BANK_SH = 5'(BANK_W);

  logic [4:0]        w_cw;
  logic [4:0]        w_rw;
  logic [4:0]        w_bo;
  logic [31:0]       w_word;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [BANK_W-1:0] w_bank;
  logic [COL_W-1:0]  w_pmask;
  logic [COL_W-1:0]  w_bmask;
  logic [COL_W-1:0]  w_cnt_next;
  logic [ADR_W-1:0]  w_mux;
  logic              w_sdram;
  logic              w_page_hit;
  logic              w_bank_open;

  logic [BANK_W-1:0] r_bank;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADR_W-1:0]  r_waddr;
  logic [COL_W-1:0]  r_cnt;
  logic [COL_W-1:0]  r_start;
  logic              r_active;

  assign w_cw    = col_bits(bus.csc[5:4], bus.csc[7:6]);
  assign w_rw    = row_bits(bus.csc[5:4], bus.csc[7:6]);
  assign w_bo    = byte_shift(bus.csc[5:4]);
  assign w_word  = bus.wb_addr_i >> w_bo;
  assign w_col   = COL_W'(w_word & low_mask(w_cw));
  assign w_pmask = COL_W'(low_mask(w_cw));
  assign w_sdram = (bus.csc[3:1] == MC_MEM_TYPE_SDRAM);

  always_comb begin
    w_bank = '0;
    w_row  = '0;
    if (bus.csc[9]) begin
      w_row  = ROW_W'((w_word >> w_cw) & low_mask(w_rw));
      w_bank = BANK_W'(w_word >> (w_cw + w_rw));
    end else begin
      w_bank = BANK_W'(w_word >> w_cw);
      w_row  = ROW_W'((w_word >> (w_cw + BANK_SH)) & low_mask(w_rw));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_waddr <= '0;
    end else if (bus.cs_le) begin
      r_bank  <= w_bank;
      r_row   <= w_row;
      r_col   <= w_col;
      r_waddr <= ADR_W'(w_word);
    end
  end

  // Wrap mask: only the masked low bits advance; BL=1 gives an all-zero mask and holds.
  always_comb begin
    w_bmask = '0;
    case (bus.tms[2:0])
      MC_BL_2:    w_bmask = COL_W'(1);
      MC_BL_4:    w_bmask = COL_W'(3);
      MC_BL_8:    w_bmask = COL_W'(7);
      MC_BL_PAGE: w_bmask = w_pmask;
      default:    w_bmask = '0;
    endcase
  end

  assign w_cnt_next = (r_cnt & ~w_bmask) | ((r_cnt + COL_W'(1)) & w_bmask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_start  <= '0;
      r_active <= 1'b0;
    end else if (bus.col_go) begin
      r_cnt    <= r_col;
      r_start  <= r_col;
      r_active <= 1'b1;
    end else if (bus.next_adr) begin
      r_cnt    <= w_cnt_next;
    end
  end

  mc_open_row_tbl #(
    .ROW_W  (ROW_W),
    .BANK_W (BANK_W)
  ) u_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .act       (bus.act),
    .pre       (bus.pre),
    .pre_all   (bus.cmd_a10),
    .bank      (r_bank),
    .row       (r_row),
    .page_hit  (w_page_hit),
    .bank_open (w_bank_open)
  );

  always_comb begin
    w_mux = '0;
    if (bus.lmr_sel && !bus.cas_) begin
      w_mux = ADR_W'(bus.tms[12:0]);
    end else if (bus.row_sel) begin
      w_mux = ADR_W'({r_bank, r_row});
    end else begin
      w_mux = ADR_W'({r_bank, 2'b00, bus.cmd_a10, r_cnt});
    end
    if (bus.rfr_ack) w_mux[10] = 1'b1;
    if (!w_sdram) w_mux = r_waddr;
  end

  assign bus.mc_addr    = w_mux;
  assign bus.bank_adr   = r_bank;
  assign bus.row_adr    = r_row;
  assign bus.col_adr    = r_cnt;
  assign bus.page_size  = 11'd1 << w_cw;
  assign bus.page_hit   = w_page_hit;
  assign bus.bank_open  = w_bank_open;
  // End of burst is the beat whose offset from the start equals the wrap mask.
  assign bus.burst_last = r_active && (((r_cnt - r_start) & w_bmask) == w_bmask);

endmodule
`default_nettype wire

// File: tb/tb_mc_adr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mc_adr_gen : directed self-checking bench for mc_adr_gen
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mc_adr_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_tot  = 0;

  mc_adr_gen_if bus ();

  mc_adr_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic latch(input logic [31:0] a);
    bus.wb_addr_i = a;
    bus.cs_le     = 1'b1;
    cyc();
    bus.cs_le     = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.csc       = 32'h20;
    bus.tms       = 32'h2;
    bus.wb_addr_i = '0;
    bus.cs_le     = 1'b0;
    bus.act       = 1'b0;
    bus.pre       = 1'b0;
    bus.rfr_ack   = 1'b0;
    bus.lmr_sel   = 1'b0;
    bus.cas_      = 1'b1;
    bus.row_sel   = 1'b0;
    bus.cmd_a10   = 1'b0;
    bus.col_go    = 1'b0;
    bus.next_adr  = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // start a burst and open a bank, then reset in the middle of it
    latch(32'h18);
    bus.col_go = 1'b1; bus.act = 1'b1; cyc(); bus.col_go = 1'b0; bus.act = 1'b0;
    bus.next_adr = 1'b1; cyc(); bus.next_adr = 1'b0;
    chk("pre_rst_col", 32'(bus.col_adr), 32'h7);
    chk("pre_rst_open", 32'(bus.bank_open), 32'h1);
    rst_n = 1'b0; cyc(); cyc();
    chk("rst_col", 32'(bus.col_adr), 32'h0);
    chk("rst_bank", 32'(bus.bank_adr), 32'h0);
    chk("rst_row", 32'(bus.row_adr), 32'h0);
    chk("rst_mc_addr", 32'(bus.mc_addr), 32'h0);
    chk("rst_page_hit", 32'(bus.page_hit), 32'h0);
    chk("rst_bank_open", 32'(bus.bank_open), 32'h0);
    chk("rst_burst_last", 32'(bus.burst_last), 32'h0);
    rst_n = 1'b1;

    // 32-bit / 64Mb / bank-after-column decode
    latch(32'h1C08);
    chk("dec_bank", 32'(bus.bank_adr), 32'h3);
    chk("dec_row", 32'(bus.row_adr), 32'h1);
    chk("dec_page_size", 32'(bus.page_size), 32'd256);
    bus.row_sel = 1'b1; #1;
    chk("row_mux", 32'(bus.mc_addr), 32'h6001);
    bus.row_sel = 1'b0;
    bus.col_go = 1'b1; cyc(); bus.col_go = 1'b0;
    chk("dec_col", 32'(bus.col_adr), 32'h2);
    chk("col_mux", 32'(bus.mc_addr), 32'h6002);
    chk("bl4_first_not_last", 32'(bus.burst_last), 32'h0);

    // open-row table
    chk("closed_before_act", 32'(bus.bank_open), 32'h0);
    bus.act = 1'b1; cyc(); bus.act = 1'b0;
    chk("hit_after_act", 32'(bus.page_hit), 32'h1);
    latch(32'h1C0C);
    chk("hit_same_row", 32'(bus.page_hit), 32'h1);
    chk("open_same_row", 32'(bus.bank_open), 32'h1);
    latch(32'h2C00);
    chk("miss_other_row", 32'(bus.page_hit), 32'h0);
    chk("open_other_row", 32'(bus.bank_open), 32'h1);
    chk("row_other", 32'(bus.row_adr), 32'h2);
    bus.pre = 1'b1; bus.cmd_a10 = 1'b1; cyc(); bus.pre = 1'b0; bus.cmd_a10 = 1'b0;
    chk("pre_all_closes", 32'(bus.bank_open), 32'h0);
    bus.act = 1'b1; cyc(); bus.act = 1'b0;
    latch(32'h0);
    bus.act = 1'b1; cyc(); bus.act = 1'b0;
    chk("bank0_open", 32'(bus.bank_open), 32'h1);
    bus.pre = 1'b1; cyc(); bus.pre = 1'b0;
    chk("pre_one_closes", 32'(bus.bank_open), 32'h0);
    latch(32'h2C00);
    chk("pre_one_keeps_other", 32'(bus.page_hit), 32'h1);
    bus.act = 1'b1; bus.pre = 1'b1; cyc(); bus.act = 1'b0; bus.pre = 1'b0;
    chk("act_pre_pre_wins", 32'(bus.bank_open), 32'h0);

    // BL=4 sequential wrap from column 6
    latch(32'h18);
    bus.col_go = 1'b1; cyc(); bus.col_go = 1'b0;
    chk("bl4_c6", 32'(bus.col_adr), 32'h6);
    bus.next_adr = 1'b1; cyc();
    chk("bl4_c7", 32'(bus.col_adr), 32'h7);
    chk("bl4_c7_last", 32'(bus.burst_last), 32'h0);
    cyc();
    chk("bl4_c4", 32'(bus.col_adr), 32'h4);
    chk("bl4_c4_last", 32'(bus.burst_last), 32'h0);
    cyc();
    chk("bl4_c5", 32'(bus.col_adr), 32'h5);
    chk("bl4_c5_last", 32'(bus.burst_last), 32'h1);
    bus.col_go = 1'b1; cyc(); bus.col_go = 1'b0; bus.next_adr = 1'b0;
    chk("col_go_wins", 32'(bus.col_adr), 32'h6);

    // 16-bit / 128Mb / bank-after-row decode
    bus.csc = 32'h250;
    latch(32'h0080_1422);
    chk("bas_bank", 32'(bus.bank_adr), 32'h2);
    chk("bas_row", 32'(bus.row_adr), 32'h5);
    chk("bas_page_size", 32'(bus.page_size), 32'd512);

    // full page 8-bit / 64Mb from the last column
    bus.csc = 32'h0;
    bus.tms = 32'h7;
    latch(32'h1FF);
    bus.col_go = 1'b1; cyc(); bus.col_go = 1'b0;
    chk("page_start", 32'(bus.col_adr), 32'h1FF);
    chk("page_start_last", 32'(bus.burst_last), 32'h0);
    bus.next_adr = 1'b1; cyc();
    chk("page_wrap", 32'(bus.col_adr), 32'h0);
    repeat (510) cyc();
    bus.next_adr = 1'b0;
    chk("page_1fe", 32'(bus.col_adr), 32'h1FE);
    chk("page_1fe_last", 32'(bus.burst_last), 32'h1);
    bus.next_adr = 1'b1; cyc(); bus.next_adr = 1'b0;
    chk("page_back", 32'(bus.col_adr), 32'h1FF);
    chk("page_back_last", 32'(bus.burst_last), 32'h0);

    // refresh A10 force and load-mode register select
    bus.tms = 32'h2;
    latch(32'h0);
    bus.row_sel = 1'b1; bus.rfr_ack = 1'b1; #1;
    chk("rfr_a10", 32'(bus.mc_addr), 32'h400);
    bus.rfr_ack = 1'b0; bus.lmr_sel = 1'b1; bus.cas_ = 1'b0; bus.tms = 32'h32; #1;
    chk("lmr_mux", 32'(bus.mc_addr), 32'h32);
    bus.cas_ = 1'b1; #1;
    chk("lmr_needs_cas", 32'(bus.mc_addr), 32'h0);
    bus.lmr_sel = 1'b0; bus.row_sel = 1'b0;

    // non-SDRAM devices get the latched word address
    bus.csc = 32'h22;
    latch(32'h00AB_CDE0);
    chk("async_addr", 32'(bus.mc_addr), 32'h2AF378);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
